// File: rtl/node_package.sv
// rtl/node_package.sv - shared node types and link-stage sizing
package node_package;

    // Request-channel flit carried between request and subordinate nodes
    typedef struct packed {
        logic [1:0] opcode;
        logic [5:0] addr;
    } ReqType;

    localparam int REQ_LINK_DEPTH = 4;

endpackage

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - generic count-tracked storage FIFO for link stages
module link_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is never cleared; stale entries are unreachable once count is reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count alone decides full/empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/req_link_buf.sv
// rtl/req_link_buf.sv - buffered pre_/v_ link stage on the request channel
module req_link_buf
    import node_package::*;
#(
    parameter int DEPTH = REQ_LINK_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    output logic   pre_rx_req,
    input  ReqType rx_req,
    input  logic   v_rx_req,
    input  logic   pre_tx_req,
    output ReqType tx_req,
    output logic   v_tx_req,
    output logic   err_ovf
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          pre_q;
    logic [CW-1:0] count;
    logic [CW:0]   reserved;
    logic          push;
    logic          pop;
    ReqType        head;

    // Slots already held plus the one that may be in flight from last cycle's grant
    assign reserved   = {1'b0, count} + {{CW{1'b0}}, pre_q};
    assign pre_rx_req = !reset && (reserved < (CW + 1)'(DEPTH));

    // Only flits arriving on a granted cycle are stored; pop sees pre-push count
    assign push = v_rx_req && pre_q;
    assign pop  = pre_tx_req && (count != '0);

    link_fifo #(
        .T     (ReqType),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_req),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Remember this cycle's grant so the next cycle knows a flit may arrive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= 1'b0;
        end else begin
            pre_q <= pre_rx_req;
        end
    end

    // Registered output stage and sticky violation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_req   <= '0;
            v_tx_req <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            v_tx_req <= pop;
            if (pop) begin
                tx_req <= head;
            end
            if (v_rx_req && !pre_q) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_req_link_buf.sv
// tb/tb_req_link_buf.sv - scoreboard bench for req_link_buf
module tb_req_link_buf;
    import node_package::*;

    localparam int DEPTH = REQ_LINK_DEPTH;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   pre_rx_req;
    ReqType rx_req = '0;
    logic   v_rx_req = 1'b0;
    logic   pre_tx_req = 1'b0;
    ReqType tx_req;
    logic   v_tx_req;
    logic   err_ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] model_q [$];
    exp_t       exp_q [$];
    bit         last_grant = 1'b0;
    bit         err_exp = 1'b0;
    bit         accepted;

    req_link_buf #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pre_rx_req (pre_rx_req),
        .rx_req     (rx_req),
        .v_rx_req   (v_rx_req),
        .pre_tx_req (pre_tx_req),
        .tx_req     (tx_req),
        .v_tx_req   (v_tx_req),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented flit must match the oldest expectation, on time
    always @(posedge clk) begin
        #1;
        if (v_tx_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", {24'h0, tx_req}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tx_data", {24'h0, tx_req}, {24'h0, e.data});
                check("tx_cycle", cyc, e.cyc);
            end
        end
    end

    // One link cycle: check grant/flag, update reference model, drive inputs
    task automatic step(input bit send, input bit ptx, input logic [7:0] d, input bit viol);
        bit v;
        @(negedge clk);
        check("pre_rx_req", {31'h0, pre_rx_req},
              {31'h0, (model_q.size() + int'(last_grant)) < DEPTH});
        check("err_ovf", {31'h0, err_ovf}, {31'h0, err_exp});
        if (ptx && model_q.size() > 0) begin
            exp_t e;
            e.data = model_q.pop_front();
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        v = viol || (send && last_grant);
        accepted = 1'b0;
        if (v) begin
            if (last_grant) begin
                model_q.push_back(d);
                accepted = 1'b1;
            end else begin
                err_exp = 1'b1;
            end
        end
        v_rx_req   = v;
        rx_req     = ReqType'(d);
        pre_tx_req = ptx;
        last_grant = pre_rx_req;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        v_rx_req   = 1'b0;
        pre_tx_req = 1'b0;
        #1;
        check("rst_v_tx_req", {31'h0, v_tx_req}, 32'h0);
        check("rst_pre_rx_req", {31'h0, pre_rx_req}, 32'h0);
        check("rst_err_ovf", {31'h0, err_ovf}, 32'h0);
        model_q.delete();
        exp_q.delete();
        err_exp    = 1'b0;
        last_grant = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("first_grant", {31'h0, pre_rx_req}, 32'h1);
        last_grant = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nxt;

        // Reset state
        @(negedge clk);
        check("reset_pre_rx", {31'h0, pre_rx_req}, 32'h0);
        check("reset_v_tx", {31'h0, v_tx_req}, 32'h0);
        check("reset_tx", {24'h0, tx_req}, 32'h0);
        check("reset_err", {31'h0, err_ovf}, 32'h0);
        reset = 1'b0;
        #1;
        check("first_grant", {31'h0, pre_rx_req}, 32'h1);
        last_grant = 1'b1;

        // Single flit, downstream grant from the following cycle
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Fill to full with downstream stalled
        nxt = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, nxt, 1'b0);
            if (accepted) nxt++;
        end

        // Violation while full: dropped, flag set
        step(1'b0, 1'b0, 8'h77, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Drain in order on consecutive cycles
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Streaming with both grants high, wraps the pointers
        nxt = 8'h20;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, nxt, 1'b0);
            if (accepted) nxt++;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Lapsed grants, then one flit
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h5C, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Randomized traffic with occasional violations
        for (int i = 0; i < 400; i++) begin
            bit s, p, vio;
            s   = ($urandom_range(0, 3) != 0);
            p   = ($urandom_range(0, 3) != 0);
            vio = !last_grant && ($urandom_range(0, 40) == 0);
            step(s, p, 8'($urandom), vio);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Mid-stream reset with two flits stored
        for (int i = 0; i < 10 && model_q.size() < 2; i++) step(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
        do_reset();

        // After reset only fresh flits may appear
        nxt = 8'hC0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, nxt, 1'b0);
            if (accepted) nxt++;
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("missing_flits", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
